rep3_serial_tx: RTL and testbench

Serial transmitter for the triple-repetition line code. The receive side decodes each data bit by 2-of-3 majority vote, built on the `maj3` gate. This block takes parallel words over a valid/ready handshake and frames them on a single line. It drives every symbol (start, data, optional parity, stop) as three consecutive identical chips, so one corrupted chip per symbol is voted out at the far end.

---
 rtl/rep3_pkg.sv | 20 ++
 rtl/rep3_serial_tx_if.sv | 11 +
 rtl/rep3_chip_timer.sv | 46 ++++
 rtl/rep3_serial_tx.sv | 127 ++++++++++++
 tb/tb_rep3_serial_tx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rep3_pkg.sv
// Shared types and helpers for the triple-repetition line code (transmitter, receiver, benches).
package rep3_pkg;

    localparam int unsigned REP = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rep3_tx_state_t;

    function automatic int unsigned rep3_frame_cycles(input int unsigned data_w,
                                                      input int unsigned clk_per_chip,
                                                      input bit          parity);
        return REP * clk_per_chip * (data_w + 2 + (parity ? 1 : 0));
    endfunction

endpackage

// File: rtl/rep3_serial_tx_if.sv
// Parallel word handshake into the rep3 serial transmitter.
interface rep3_serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rep3_chip_timer.sv
// Cycle/chip counters for one repeated symbol; strobes at the end of each chip and symbol.
module rep3_chip_timer
    import rep3_pkg::*;
#(
    parameter int unsigned CLK_PER_CHIP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic chip_end,
    output logic sym_end
);

    localparam int unsigned CycW = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;

    logic [CycW-1:0] cyc_q, cyc_d;
    logic [1:0]      chip_q, chip_d;

    assign chip_end = (cyc_q == CycW'(CLK_PER_CHIP - 1));
    assign sym_end  = chip_end && (chip_q == 2'(REP - 1));

    always_comb begin
        cyc_d  = cyc_q;
        chip_d = chip_q;
        if (clear) begin
            cyc_d  = '0;
            chip_d = '0;
        end else if (chip_end) begin
            cyc_d  = '0;
            chip_d = sym_end ? 2'd0 : chip_q + 2'd1;
        end else begin
            cyc_d = cyc_q + CycW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q  <= '0;
            chip_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            chip_q <= chip_d;
        end
    end

endmodule

// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter: start, data LSB first, optional even parity, stop.
// Parity symbol is compiled in when REP3_TX_PARITY_EN is defined.
module rep3_serial_tx
    import rep3_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLK_PER_CHIP = 4
) (
    input  logic             clk,
    input  logic             reset,
    rep3_serial_tx_if.slave  tx,
    output logic             tx_line,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rep3_tx_state_t    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              line_q, line_d;
    logic              chip_end, sym_end;
    logic              timer_clear;
`ifdef REP3_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Idle holds the timer at zero so every symbol starts from a clean count.
    assign timer_clear = (state_q == StIdle) || (state_d != state_q);

    rep3_chip_timer #(
        .CLK_PER_CHIP (CLK_PER_CHIP)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .chip_end (chip_end),
        .sym_end  (sym_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef REP3_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (tx.tx_valid) begin
                    state_d = StStart;
                    shift_d = tx.tx_data;
`ifdef REP3_TX_PARITY_EN
                    parity_d = ^tx.tx_data;
`endif
                end
            end
            StStart: begin
                if (sym_end) state_d = StData;
            end
            StData: begin
                if (sym_end) begin
                    if (idx_q == IdxW'(DATA_W - 1)) begin
`ifdef REP3_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef REP3_TX_PARITY_EN
            StParity: begin
                if (sym_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (sym_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) idx_d = '0;
    end

    // Line is registered from next state so it moves with the state on chip boundaries.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_d[0];
`ifdef REP3_TX_PARITY_EN
            StParity: line_d = parity_q;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            line_q  <= 1'b1;
`ifdef REP3_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
`ifdef REP3_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_line     = line_q;
    assign busy        = (state_q != StIdle);
    assign tx.tx_ready = (state_q == StIdle);
    assign frame_done  = (state_q == StStop) && sym_end;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Scoreboard bench for rep3_serial_tx: default instance plus a DATA_W=1, CLK_PER_CHIP=1 instance.
module tb_rep3_serial_tx;

`ifdef REP3_TX_PARITY_EN
    localparam int FC_A = 132;
    localparam int NSYM_A = 11;
    localparam int FC_B = 12;
    localparam int NSYM_B = 4;
`else
    localparam int FC_A = 120;
    localparam int NSYM_A = 10;
    localparam int FC_B = 9;
    localparam int NSYM_B = 3;
`endif
    localparam int CPC_A = 4;

    typedef struct {
        logic [7:0] data;
        bit         abort;
        bit         b2b;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tx_line_a, busy_a, frame_done_a;
    logic tx_line_b, busy_b, frame_done_b;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int last_end_a = -100;
    bit in_frame_a = 0;

    exp_t exp_a[$];
    logic exp_b[$];

    rep3_serial_tx_if #(.DATA_W(8)) ifa ();
    rep3_serial_tx_if #(.DATA_W(1)) ifb ();

    rep3_serial_tx #(.DATA_W(8), .CLK_PER_CHIP(4)) dut_a (
        .clk        (clk),
        .reset      (rst_n),
        .tx         (ifa),
        .tx_line    (tx_line_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    rep3_serial_tx #(.DATA_W(1), .CLK_PER_CHIP(1)) dut_b (
        .clk        (clk),
        .reset      (rst_n),
        .tx         (ifb),
        .tx_line    (tx_line_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Monitor for the default instance: checks every cycle of each frame against the queue head.
    initial begin : mon_a
        exp_t e;
        logic sym [0:NSYM_A-1];
        bit   aborted, chip_ok, fd_ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy_a === 1'b1) begin
                check("frame_queue_a", (exp_a.size() > 0), 1);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    if (e.b2b) check("b2b_gap", cyc_n - last_end_a, 2);
                    sym[0] = 1'b0;
                    for (int i = 0; i < 8; i++) sym[1 + i] = e.data[i];
`ifdef REP3_TX_PARITY_EN
                    sym[9] = ^e.data;
`endif
                    sym[NSYM_A - 1] = 1'b1;
                    in_frame_a = 1;
                    aborted = 0;
                    chip_ok = 1;
                    fd_ok = 1;
                    for (int c = 0; c < FC_A; c++) begin
                        if (c > 0) begin
                            @(negedge clk or negedge rst_n);
                            if (!rst_n) begin
                                aborted = 1;
                                break;
                            end
                        end
                        if (tx_line_a !== sym[c / (3 * CPC_A)] || busy_a !== 1'b1) chip_ok = 0;
                        if (frame_done_a !== (c == FC_A - 1)) fd_ok = 0;
                        if (c % (3 * CPC_A) == 3 * CPC_A - 1) begin
                            check($sformatf("sym%0d_data%02h", c / (3 * CPC_A), e.data), chip_ok, 1);
                            chip_ok = 1;
                        end
                    end
                    if (aborted) begin
                        #1;
                        check("reset_async_outputs", {tx_line_a, busy_a, frame_done_a}, 3'b100);
                        check("abort_expected", e.abort, 1);
                    end else begin
                        check("frame_done_timing", fd_ok, 1);
                        check("abort_expected", e.abort, 0);
                        last_end_a = cyc_n;
                        @(negedge clk);
                        check("post_frame_idle", {tx_line_a, ifa.tx_ready, busy_a, frame_done_a},
                              4'b1100);
                    end
                    in_frame_a = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (frame_done_a === 1'b1 && !in_frame_a) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_frame_done: got 1, expected 0 (t=%0t)", $time);
        end
    end

    // Monitor for the 1-bit, 1-cycle-chip instance, including a majority-vote receiver model.
    initial begin : mon_b
        logic d;
        logic ch [0:FC_B-1];
        logic symb [0:NSYM_B-1];
        logic v [0:2];
        bit   fd_ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && busy_b === 1'b1) begin
                check("frame_queue_b", (exp_b.size() > 0), 1);
                if (exp_b.size() > 0) begin
                    d = exp_b.pop_front();
                    symb[0] = 1'b0;
                    symb[1] = d;
`ifdef REP3_TX_PARITY_EN
                    symb[2] = d;
`endif
                    symb[NSYM_B - 1] = 1'b1;
                    fd_ok = 1;
                    for (int c = 0; c < FC_B; c++) begin
                        if (c > 0) @(negedge clk);
                        ch[c] = tx_line_b;
                        if (frame_done_b !== (c == FC_B - 1)) fd_ok = 0;
                    end
                    for (int s = 0; s < NSYM_B; s++)
                        check($sformatf("b_sym%0d", s), {ch[3 * s], ch[3 * s + 1], ch[3 * s + 2]},
                              {3{symb[s]}});
                    check("b_frame_done", fd_ok, 1);
                    for (int f = 0; f < 3; f++) begin
                        for (int k = 0; k < 3; k++) v[k] = ch[3 + k] ^ (k == f);
                        check($sformatf("b_maj_flip%0d", f), maj3(v[0], v[1], v[2]), d);
                    end
                    @(negedge clk);
                    check("b_post_idle", {tx_line_b, ifb.tx_ready, busy_b}, 3'b110);
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input bit ab);
        bit ok;
        exp_a.push_back('{data: d, abort: ab, b2b: 1'b0});
        @(negedge clk);
        ifa.tx_data  = d;
        ifa.tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (busy_a === 1'b1) ok = 1;
        end
        ifa.tx_valid = 1'b0;
        check("accept_a", ok, 1);
    endtask

    task automatic send_b(input logic d);
        bit ok;
        exp_b.push_back(d);
        @(negedge clk);
        ifb.tx_data  = d;
        ifb.tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (busy_b === 1'b1) ok = 1;
        end
        ifb.tx_valid = 1'b0;
        check("accept_b", ok, 1);
    endtask

    task automatic wait_busy_a(input logic lvl, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_a === lvl) break;
        end
        check(nm, busy_a, lvl);
    endtask

    task automatic wait_drain;
        bit done;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_b.size() == 0 && !busy_a && !busy_b && !in_frame_a)
                done = 1;
        end
        check("drain", done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.tx_valid = 1'b0;
        ifa.tx_data  = '0;
        ifb.tx_valid = 1'b0;
        ifb.tx_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_a", {tx_line_a, ifa.tx_ready, busy_a, frame_done_a}, 4'b1100);
        end
        check("idle_b", {tx_line_b, ifb.tx_ready, busy_b, frame_done_b}, 4'b1100);

        send_a(8'hA5, 1'b0);
        wait_drain();
        send_a(8'h01, 1'b0);
        wait_drain();

        // Valid held high across two frames; data changes mid-frame must not leak in.
        exp_a.push_back('{data: 8'h3C, abort: 1'b0, b2b: 1'b0});
        exp_a.push_back('{data: 8'hC3, abort: 1'b0, b2b: 1'b1});
        @(negedge clk);
        ifa.tx_data  = 8'h3C;
        ifa.tx_valid = 1'b1;
        wait_busy_a(1'b1, "b2b_first_start");
        repeat (30) @(negedge clk);
        ifa.tx_data = 8'hC3;
        wait_busy_a(1'b0, "b2b_idle_gap");
        wait_busy_a(1'b1, "b2b_second_start");
        repeat (30) @(negedge clk);
        ifa.tx_data  = 8'h00;
        ifa.tx_valid = 1'b0;
        wait_drain();

        // Reset in cycle 50 of a frame (data bit 3 of 0x00, line low).
        send_a(8'h00, 1'b1);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        send_a(8'hFF, 1'b0);
        wait_drain();

        send_b(1'b1);
        wait_drain();
        send_b(1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
